mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
- Shares the system bus (instruction/data memory, keypad, seven-segment register) between two masters.
- Master 0 is the bird CPU; master 1 is the loader/debug port.
- Performs round-robin arbitration, memory-map decode, the memory-latency wait state, the keypad read-clear handshake, and owns the seven-segment output register.
- Sits between the masters and the memory/IO blocks in the top level.

Parameters:
- BEGINMEM, 12'h000, first memory address
- ENDMEM, 12'h6ff, last memory address
- KEYPAD, 12'h900, keypad data address; KEYPAD+1 is keypad status
- SEVENSEG, 12'hb00, seven-segment register address
- UNMAPPED_DATA, 16'hf345, read data returned for unmapped addresses

Ports:
- clk  in  1  system clock, all logic on posedge
- reset  in  1  asynchronous, active-high reset
- m0_req  in  1  master 0 request; held until m0_ack
- m0_we  in  1  master 0 write enable (1 = write)
- m0_addr  in  12  master 0 address
- m0_wdata  in  16  master 0 write data
- m0_rdata  out  16  master 0 read data, valid while m0_ack=1
- m0_ack  out  1  master 0 one-cycle completion pulse
- m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ack: same as m0_* for master 1
- mem_addr  out  12  memory address
- mem_we  out  1  memory write strobe
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data, registered, 1-cycle latency
- kp_a0  out  1  keypad register select (addr[0])
- kp_readyclr  out  1  one-cycle pulse clearing the keypad ready flag
- kp_data  in  16  keypad read data, combinational on kp_a0
- ss7  out  16  seven-segment display value register

Behaviour:
- Reset (async, active-high): state=IDLE; m0_ack=m1_ack=0; m0_rdata=m1_rdata=0; mem_we=0; mem_addr=0; mem_wdata=0; kp_readyclr=0; kp_a0=0; ss7=16'h0000; last_grant=1, so master 0 wins first.
- FSM states:
  - IDLE: if any req, grant and go to ADDR.
  - ADDR: drive bus for one cycle, then go to DATA.
  - DATA: capture read data, pulse ack, return to IDLE.
- Arbitration (in IDLE only):
  - One requester: grant it.
  - Both requesting: grant the one not equal to last_grant, then update last_grant.
  - The grant, we, addr and wdata of the granted master are latched on entry to ADDR; later master input changes are ignored.
- Latency: req first seen high in IDLE at edge N -> ack high for exactly the cycle after edge N+2 -> back in IDLE at N+3. One access per 3 cycles per bus.
- Decode, on the latched address:
  - MEM: BEGINMEM..ENDMEM.
  - KP: KEYPAD..KEYPAD+1.
  - SS: == SEVENSEG.
  - Anything else is unmapped.
- ADDR outputs by region:
  - MEM: mem_addr=addr; mem_we=we; mem_wdata=wdata.
  - KP: kp_a0=addr[0]. kp_readyclr=1 only if read and addr==KEYPAD. Writes to KP are ignored.
  - SS write: ss7<=wdata at the ADDR->DATA edge. SS read returns current ss7.
  - Unmapped write: no side effect.
  - mem_we is 0 in every state except ADDR with a MEM write.
- DATA read data into the granted master's rdata:
  - MEM: mem_rdata.
  - KP: kp_data.
  - SS: ss7.
  - Unmapped: UNMAPPED_DATA.
  - For writes, rdata holds its previous value.
- The non-granted master's ack stays 0 and its rdata is unchanged.
- Requester rules:
  - A master dropping req before ack aborts nothing: the access completes and ack still pulses.
  - A master holding req after ack is re-arbitrated in the following IDLE cycle (new access).
- Reset mid-transaction: immediately IDLE, no ack. A pending memory write in ADDR is cut off (mem_we forced 0). ss7 returns to 0.
- Boundaries: address ENDMEM is MEM; ENDMEM+1 is unmapped; KEYPAD+2 is unmapped; 12'hfff is unmapped.

Decomposition:
- Shared package mem_map_pkg holds:
  - constants BEGINMEM, ENDMEM, KEYPAD, SEVENSEG, UNMAPPED_DATA;
  - state encoding IDLE/ADDR/DATA;
  - region encoding MEM/KP/SS/NONE.
- One sub-module is natural: addr_decode, purely combinational, taking a 12-bit address and producing the region code. It is reused by the top level for any future peripheral.

Test Plan:
- Reset then m0 write 16'h1234 to 12'h010 -> mem_we=1 for one cycle with mem_addr=12'h010. m0 read 12'h010 -> m0_ack at cycle N+2 with m0_rdata=16'h1234.
- m0 and m1 both raise req in the same cycle, held through ack -> grants alternate m0, m1, m0, m1. Each ack occurs 3 cycles after the previous one; the other master's ack stays 0.
- m1 read 12'h900 with kp_data=16'h0005 -> kp_readyclr pulses exactly once and kp_a0=0; m1_rdata=16'h0005. A read of 12'h901 -> kp_a0=1 and no readyclr.
- m0 write 16'hbeef to 12'hb00 -> ss7=16'hbeef. Read 12'hb00 -> 16'hbeef. Write to 12'h700 -> no mem_we and ss7 unchanged; read of 12'h700 returns 16'hf345.
- Assert reset during ADDR of a memory write -> mem_we drops immediately, no ack, ss7=0. After release, m0 is granted first when both masters request.

Source files
------------

// File: rtl/mem_map_pkg.sv
// rtl/mem_map_pkg.sv - memory map constants, FSM and region encodings for mem_bus_arbiter
package mem_map_pkg;

  localparam logic [11:0] BEGINMEM      = 12'h000;
  localparam logic [11:0] ENDMEM        = 12'h6ff;
  localparam logic [11:0] KEYPAD        = 12'h900;
  localparam logic [11:0] SEVENSEG      = 12'hb00;
  localparam logic [15:0] UNMAPPED_DATA = 16'hf345;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

  typedef enum logic [1:0] {MEM, KP, SS, NONE} region_e;

  // Range test as a function so a zero lower bound does not fold into a constant compare.
  function automatic logic in_range(input logic [11:0] a, input logic [11:0] lo,
                                    input logic [11:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - two-master bus, memory and IO signals of mem_bus_arbiter
interface mem_bus_arbiter_if;

  logic        m0_req;
  logic        m0_we;
  logic [11:0] m0_addr;
  logic [15:0] m0_wdata;
  logic [15:0] m0_rdata;
  logic        m0_ack;

  logic        m1_req;
  logic        m1_we;
  logic [11:0] m1_addr;
  logic [15:0] m1_wdata;
  logic [15:0] m1_rdata;
  logic        m1_ack;

  logic [11:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        kp_a0;
  logic        kp_readyclr;
  logic [15:0] kp_data;
  logic [15:0] ss7;

  // Arbiter side.
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  mem_rdata, kp_data,
    output m0_rdata, m0_ack, m1_rdata, m1_ack,
    output mem_addr, mem_we, mem_wdata, kp_a0, kp_readyclr, ss7
  );

  // Masters plus memory/IO side.
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output mem_rdata, kp_data,
    input  m0_rdata, m0_ack, m1_rdata, m1_ack,
    input  mem_addr, mem_we, mem_wdata, kp_a0, kp_readyclr, ss7
  );

endinterface

// File: rtl/mem_bus_arbiter_addr_decode.sv
// rtl/mem_bus_arbiter_addr_decode.sv - combinational address to region decode
module addr_decode
  import mem_map_pkg::*;
(
  input  logic [11:0] addr_i,
  output region_e     region_o
);

  always_comb begin
    region_o = NONE;
    if (in_range(addr_i, BEGINMEM, ENDMEM)) begin
      region_o = MEM;
    end else if (in_range(addr_i, KEYPAD, KEYPAD + 12'd1)) begin
      region_o = KP;
    end else if (addr_i == SEVENSEG) begin
      region_o = SS;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin two-master arbiter with memory map decode,
// keypad read-clear handshake and seven-segment register
module mem_bus_arbiter
  import mem_map_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  mem_bus_arbiter_if.slave   bus
);

  state_e      state_q;
  logic        last_grant_q;
  logic        grant_q;
  logic        we_q;
  logic [15:0] wdata_q;
  region_e     region_q;

  logic        m0_ack_q, m1_ack_q;
  logic [15:0] m0_rdata_q, m1_rdata_q;
  logic [11:0] mem_addr_q;
  logic        mem_we_q;
  logic [15:0] mem_wdata_q;
  logic        kp_a0_q;
  logic        kp_readyclr_q;
  logic [15:0] ss7_q;

  logic        any_req;
  logic        sel_d;
  logic        sel_we;
  logic [11:0] sel_addr;
  logic [15:0] sel_wdata;
  region_e     sel_region;
  logic [15:0] rd_data;

  always_comb begin
    any_req = bus.m0_req | bus.m1_req;
    // On contention the master that did not win last time gets the bus.
    if (bus.m0_req && bus.m1_req) begin
      sel_d = ~last_grant_q;
    end else begin
      sel_d = bus.m1_req;
    end
    sel_we    = sel_d ? bus.m1_we    : bus.m0_we;
    sel_addr  = sel_d ? bus.m1_addr  : bus.m0_addr;
    sel_wdata = sel_d ? bus.m1_wdata : bus.m0_wdata;
  end

  addr_decode u_addr_decode (
    .addr_i   (sel_addr),
    .region_o (sel_region)
  );

  always_comb begin
    rd_data = UNMAPPED_DATA;
    unique case (region_q)
      MEM:     rd_data = bus.mem_rdata;
      KP:      rd_data = bus.kp_data;
      SS:      rd_data = ss7_q;
      default: rd_data = UNMAPPED_DATA;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      grant_q       <= 1'b0;
      we_q          <= 1'b0;
      wdata_q       <= 16'h0000;
      region_q      <= NONE;
      m0_ack_q      <= 1'b0;
      m1_ack_q      <= 1'b0;
      m0_rdata_q    <= 16'h0000;
      m1_rdata_q    <= 16'h0000;
      mem_addr_q    <= 12'h000;
      mem_we_q      <= 1'b0;
      mem_wdata_q   <= 16'h0000;
      kp_a0_q       <= 1'b0;
      kp_readyclr_q <= 1'b0;
      ss7_q         <= 16'h0000;
    end else begin
      unique case (state_q)
        IDLE: begin
          m0_ack_q <= 1'b0;
          m1_ack_q <= 1'b0;
          if (any_req) begin
            grant_q      <= sel_d;
            last_grant_q <= sel_d;
            we_q         <= sel_we;
            wdata_q      <= sel_wdata;
            region_q     <= sel_region;
            state_q      <= ADDR;
            if (sel_region == MEM) begin
              mem_addr_q  <= sel_addr;
              mem_we_q    <= sel_we;
              mem_wdata_q <= sel_wdata;
            end
            if (sel_region == KP) begin
              kp_a0_q       <= sel_addr[0];
              kp_readyclr_q <= !sel_we && (sel_addr == KEYPAD);
            end
          end
        end
        ADDR: begin
          mem_we_q      <= 1'b0;
          kp_readyclr_q <= 1'b0;
          if (region_q == SS && we_q) begin
            ss7_q <= wdata_q;
          end
          state_q <= DATA;
        end
        DATA: begin
          if (!we_q) begin
            if (grant_q) m1_rdata_q <= rd_data;
            else         m0_rdata_q <= rd_data;
          end
          m0_ack_q <= ~grant_q;
          m1_ack_q <= grant_q;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.m0_ack      = m0_ack_q;
  assign bus.m1_ack      = m1_ack_q;
  assign bus.m0_rdata    = m0_rdata_q;
  assign bus.m1_rdata    = m1_rdata_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.kp_a0       = kp_a0_q;
  assign bus.kp_readyclr = kp_readyclr_q;
  assign bus.ss7         = ss7_q;

endmodule
